// File: rtl/pito_uart_tx_arbiter.sv
// pito_uart_tx_arbiter
//   Shares one darkuart transmit channel between NREQ requesters (one per hart).
//   A round-robin pick is made in IDLE. The UART status is then polled until it
//   is not busy, and the latched byte is written to the UART buffer register.
//   The requester sees a one-cycle GNT in the same cycle as that write.
//
// Ports
//   clk_i          clock
//   res_i          synchronous reset, active-high
//   req_i          per-requester transmit request (level, held until GNT)
//   req_data_i     byte for requester i at [8*i+7:8*i]
//   gnt_o          one-hot pulse, byte of that requester written this cycle
//   owner_o        index of requester being served
//   active_o       FSM not in IDLE
//   uart_rd_o      darkuart RD
//   uart_wr_o      darkuart WR
//   uart_be_o      darkuart BE
//   uart_datai_o   darkuart DATAI
//   uart_datao_i   darkuart DATAO, bit0 = transmitter busy
//
// state  | meaning
// IDLE   | waiting for any request, round-robin pick on exit
// CHECK  | status read each cycle until the UART is not busy
// WRITE  | byte written to UART buffer, GNT to owner
// SETTLE | dead cycle so the next CHECK sees the new busy flag

module pito_uart_tx_arbiter #(
  parameter int NREQ = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [IDW-1:0]    owner_o,
  output logic              active_o,
  output logic              uart_rd_o,
  output logic              uart_wr_o,
  output logic [3:0]        uart_be_o,
  output logic [31:0]       uart_datai_o,
  input  logic [31:0]       uart_datao_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [7:0]     byte_q, byte_d;

  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [IDW:0]   cand;

  // Only the busy flag of the status word is used.
  logic unused_datao;
  assign unused_datao = ^uart_datao_i[31:1];

  // Scan ptr, ptr+1, ... mod NREQ; the sum is one bit wider so the
  // modulo works for non-power-of-two NREQ as well.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!sel_found && req_i[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          byte_d  = req_data_i[{sel_idx, 3'b000} +: 8];
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!req_i[owner_q])       state_d = ST_IDLE;
        else if (!uart_datao_i[0]) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + IDW'(1);
        state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      byte_q  <= byte_d;
    end
  end

  // All outputs depend only on registered state.
  always_comb begin
    gnt_o        = '0;
    uart_rd_o    = 1'b0;
    uart_wr_o    = 1'b0;
    uart_be_o    = 4'b0000;
    uart_datai_o = 32'h0;
    case (state_q)
      ST_CHECK: begin
        uart_rd_o = 1'b1;
        uart_be_o = 4'b0001;
      end
      ST_WRITE: begin
        uart_wr_o      = 1'b1;
        uart_be_o      = 4'b0010;
        uart_datai_o   = {16'h0, byte_q, 8'h0};
        gnt_o[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign owner_o  = owner_q;
  assign active_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pito_uart_tx_arbiter.sv
module tb_pito_uart_tx_arbiter;
  localparam int NREQ = 8;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [31:0]       datao = 32'h0;
  logic [NREQ-1:0]   gnt_o;
  logic [IDW-1:0]    owner_o;
  logic              active_o, uart_rd_o, uart_wr_o;
  logic [3:0]        uart_be_o;
  logic [31:0]       uart_datai_o;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];  // {owner, byte}

  pito_uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i(clk), .res_i(res), .req_i(req), .req_data_i(req_data),
    .gnt_o(gnt_o), .owner_o(owner_o), .active_o(active_o),
    .uart_rd_o(uart_rd_o), .uart_wr_o(uart_wr_o), .uart_be_o(uart_be_o),
    .uart_datai_o(uart_datai_o), .uart_datao_i(datao)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_tx(input int id, input logic [7:0] b);
    exp_q.push_back({IDW'(id), b});
  endtask

  task automatic set_byte(input int id, input logic [7:0] b);
    req_data[8*id +: 8] = b;
  endtask

  // Monitor: every UART write must match the oldest expected transfer.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [NREQ-1:0] eg;
    if (!res) begin
      if (uart_wr_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: owner %0d datai %h, no transfer expected", owner_o, uart_datai_o);
        end else begin
          e  = exp_q.pop_front();
          eg = '0;
          eg[e[10:8]] = 1'b1;
          if (gnt_o !== eg || owner_o !== e[10:8] || uart_datai_o !== {16'h0, e[7:0], 8'h0}
              || uart_be_o !== 4'b0010 || uart_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL uart_write: got gnt %h owner %0d datai %h be %b rd %b, expected gnt %h owner %0d datai %h be 0010 rd 0",
                     gnt_o, owner_o, uart_datai_o, uart_be_o, uart_rd_o, eg, e[10:8], {16'h0, e[7:0], 8'h0});
          end
        end
      end else if (gnt_o != '0) begin
        checks++;
        errors++;
        $display("FAIL gnt_without_write: got gnt %h, expected 00", gnt_o);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1; req = '0; datao = 32'h0;
    @(negedge clk);
    check("reset_outputs", {gnt_o, owner_o, active_o, uart_rd_o, uart_wr_o, uart_be_o},
          32'h0);
    check("reset_datai", uart_datai_o, 32'h0);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    res = 1'b0;
  endtask

  // Waits for n grants; requesters drop REQ on their GNT unless keep is set.
  task automatic run_grants(input int n, input logic keep, output int first_lat);
    int got = 0;
    int cyc = 0;
    first_lat = -1;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt_o != '0) begin
        got++;
        if (first_lat < 0) first_lat = cyc;
        if (!keep) req = req & ~gnt_o;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got %0d grants, expected %0d", got, n);
    end
  endtask

  initial begin
    int lat, rdc, wrc, gc;

    // 1: single request, UART idle
    do_reset();
    set_byte(2, 8'h41);
    expect_tx(2, 8'h41);
    req = 8'h04;
    @(negedge clk);
    check("t1_check_rd", {active_o, uart_rd_o, uart_be_o, 1'b0, owner_o}, {1'b1, 1'b1, 4'b0001, 1'b0, 3'd2});
    run_grants(1, 1'b0, lat);
    check("t1_latency", lat, 1);  // second cycle after REQ, one already consumed above
    @(negedge clk);
    check("t1_settle", {active_o, uart_rd_o, uart_wr_o, uart_be_o}, {1'b1, 6'b0});
    @(negedge clk);
    check("t1_idle", active_o, 0);

    // 2: all requesting, round-robin 0..7,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'h41 + 8'(i));
    for (int i = 0; i < NREQ; i++) expect_tx(i, 8'h41 + 8'(i));
    expect_tx(0, 8'h41);
    req = 8'hFF;
    run_grants(9, 1'b1, lat);
    req = '0;
    check("t2_first_latency", lat, 2);
    repeat (3) @(negedge clk);
    check("t2_drained", exp_q.size(), 0);

    // 3: busy UART, data change after latch ignored
    do_reset();
    set_byte(1, 8'h55);
    expect_tx(1, 8'h55);
    datao = 32'h1;
    req = 8'h02;
    rdc = 0; wrc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_rd_o) rdc++;
      if (uart_wr_o) wrc++;
      if (i == 5) set_byte(1, 8'hAA);
    end
    check("t3_rd_cycles", rdc, 20);
    check("t3_no_wr", wrc, 0);
    datao = 32'h0;
    @(negedge clk);
    check("t3_wr_after_busy", {uart_wr_o, gnt_o}, {1'b1, 8'h02});
    req = '0;
    repeat (3) @(negedge clk);

    // 4: withdraw while busy, pointer must stay at 0
    do_reset();
    set_byte(5, 8'h99);
    datao = 32'h1;
    req = 8'h20;
    @(negedge clk);
    check("t4_owner", owner_o, 5);
    req = '0;
    @(negedge clk);
    check("t4_back_idle", {active_o, uart_rd_o}, 2'b00);
    datao = 32'h0;
    set_byte(0, 8'h30); set_byte(7, 8'h37);
    expect_tx(0, 8'h30); expect_tx(7, 8'h37);
    req = 8'h81;
    run_grants(2, 1'b0, lat);
    repeat (3) @(negedge clk);

    // 5: reset in CHECK abandons the transfer
    do_reset();
    datao = 32'h1;
    set_byte(3, 8'h33);
    req = 8'h08;
    @(negedge clk);
    check("t5_in_check", {uart_rd_o, active_o}, 2'b11);
    res = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", {gnt_o, owner_o, active_o, uart_rd_o, uart_wr_o, uart_be_o}, 32'h0);
    check("t5_reset_datai", uart_datai_o, 32'h0);
    res = 1'b0;
    req = '0;
    datao = 32'h0;
    gc = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt_o != '0) gc++;
    end
    check("t5_no_gnt", gc, 0);

    // 6: wrap and priority after grants to 7 and 6
    do_reset();
    set_byte(0, 8'hA0); set_byte(6, 8'hA6); set_byte(7, 8'hA7);
    expect_tx(7, 8'hA7);
    req = 8'h80;
    run_grants(1, 1'b0, lat);
    expect_tx(0, 8'hA0); expect_tx(7, 8'hA7);
    req = 8'h81;
    run_grants(2, 1'b0, lat);
    expect_tx(6, 8'hA6);
    req = 8'h40;
    run_grants(1, 1'b0, lat);
    expect_tx(7, 8'hA7); expect_tx(0, 8'hA0);
    req = 8'h81;
    run_grants(2, 1'b0, lat);
    repeat (3) @(negedge clk);
    check("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
